// File: rtl/datamem_arbiter.sv
`timescale 1ns/1ps
// datamem_arbiter
//   Arbitrates between two requesters (0 = processor load/store, 1 = image
//   loader/filter engine) for one byte-addressed data memory. Only one
//   transaction is in flight at a time. Word stores become four byte writes.
//   Reads are timed against the memory's negedge-registered outputs.
//   Addresses outside 0..MEM_TOP are rejected without touching memory.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN, weN, szN           request, 1 = write / 0 = read, 1 = word / 0 = byte
//   addrN, wdataN            byte address and write data (byte uses [7:0])
//   gntN, doneN, errN        one-cycle pulses: accepted, completed, rejected
//   rdataN                   read result, held until the next read by that requester
//   mem_we_n, mem_a, mem_din memory write strobe (active low), address A, write byte
//   mem_b                    memory byte-read address B
//   mem_do, mem_dob          memory word read data (via A) and byte read data (via B)
//   dbg_state                current sequencer state
//
// Handshake: a requester raises reqN with its fields and holds them stable
// until gntN pulses; gntN means the fields have been latched. reqN still high
// in the cycle after gntN is a new request. Every accepted transaction ends
// with exactly one pulse of doneN, or errN in the gnt cycle if the range
// check fails.
module datamem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned MEM_TOP = 131072,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          sz0,
    input  logic          sz1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          mem_we_n,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_din,
    output logic [AW-1:0] mem_b,
    input  logic [31:0]   mem_do,
    input  logic [7:0]    mem_dob,
    output logic [1:0]    dbg_state
);

    localparam logic [AW-1:0] TOP = AW'(MEM_TOP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_nx;

    // Latched transaction (the write/read choice is carried by the state)
    logic          owner, owner_nx;
    logic          last_grant, last_nx;
    logic          op_sz, sz_nx;
    logic [AW-1:0] op_addr, addr_nx;
    logic [31:0]   op_wdata, wdata_nx;
    logic [1:0]    cnt, cnt_nx, cnt_inc;

    logic          gnt0_nx, gnt1_nx, done0_nx, done1_nx, err0_nx, err1_nx;
    logic [31:0]   rdata0_nx, rdata1_nx, rd_val;
    logic          we_n_nx;
    logic [AW-1:0] mem_a_nx, mem_b_nx;
    logic [7:0]    din_nx;

    // Winner selection for the current IDLE cycle
    logic          win;
    logic          sel_we, sel_sz, sel_bad;
    logic [AW-1:0] sel_addr, sel_end;
    logic [31:0]   sel_wdata;

    always_comb begin
        if (req0 && req1) begin
            // last_grant resets to 1 so requester 0 wins the first conflict
            win = RR_EN ? ~last_grant : 1'b0;
        end else begin
            win = ~req0;
        end
    end

    assign sel_we    = win ? we1    : we0;
    assign sel_sz    = win ? sz1    : sz0;
    assign sel_addr  = win ? addr1  : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;
    assign sel_end   = sel_addr + AW'(3);
    assign sel_bad   = (sel_addr > TOP) || (sel_sz && (sel_end > TOP));
    assign cnt_inc   = cnt + 2'd1;
    assign rd_val    = op_sz ? mem_do : {24'b0, mem_dob};
    assign dbg_state = state;

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        last_nx   = last_grant;
        sz_nx     = op_sz;
        addr_nx   = op_addr;
        wdata_nx  = op_wdata;
        cnt_nx    = cnt;
        gnt0_nx   = 1'b0;
        gnt1_nx   = 1'b0;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        err0_nx   = 1'b0;
        err1_nx   = 1'b0;
        rdata0_nx = rdata0;
        rdata1_nx = rdata1;
        we_n_nx   = 1'b1;
        mem_a_nx  = mem_a;
        mem_b_nx  = mem_b;
        din_nx    = 8'h00;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nx = win;
                    last_nx  = win;
                    sz_nx    = sel_sz;
                    addr_nx  = sel_addr;
                    wdata_nx = sel_wdata;
                    cnt_nx   = 2'd0;
                    gnt0_nx  = ~win;
                    gnt1_nx  = win;
                    if (sel_bad) begin
                        err0_nx = ~win;
                        err1_nx = win;
                    end else if (sel_we) begin
                        // First (or only) byte goes out in the gnt cycle
                        state_nx = WR;
                        we_n_nx  = 1'b0;
                        mem_a_nx = sel_addr;
                        din_nx   = sel_wdata[7:0];
                    end else begin
                        // Memory registers the read on the next negedge
                        state_nx = RD;
                        if (sel_sz) begin
                            mem_a_nx = sel_addr;
                        end else begin
                            mem_b_nx = sel_addr;
                        end
                    end
                end
            end

            WR: begin
                if (!op_sz || cnt == 2'd3) begin
                    state_nx = FIN;
                    done0_nx = ~owner;
                    done1_nx = owner;
                end else begin
                    cnt_nx   = cnt_inc;
                    we_n_nx  = 1'b0;
                    mem_a_nx = op_addr + AW'(cnt_inc);
                    din_nx   = op_wdata[{cnt_inc, 3'b000} +: 8];
                end
            end

            RD: begin
                state_nx = FIN;
                done0_nx = ~owner;
                done1_nx = owner;
                if (owner) begin
                    rdata1_nx = rd_val;
                end else begin
                    rdata0_nx = rd_val;
                end
            end

            FIN: begin
                // done is high during this cycle
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_sz      <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            cnt        <= 2'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_we_n   <= 1'b1;
            mem_a      <= '0;
            mem_b      <= '0;
            mem_din    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
            op_sz      <= sz_nx;
            op_addr    <= addr_nx;
            op_wdata   <= wdata_nx;
            cnt        <= cnt_nx;
            gnt0       <= gnt0_nx;
            gnt1       <= gnt1_nx;
            done0      <= done0_nx;
            done1      <= done1_nx;
            err0       <= err0_nx;
            err1       <= err1_nx;
            rdata0     <= rdata0_nx;
            rdata1     <= rdata1_nx;
            mem_we_n   <= we_n_nx;
            mem_a      <= mem_a_nx;
            mem_b      <= mem_b_nx;
            mem_din    <= din_nx;
        end
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Sequencer and two-requester arbiter in front of the byte-addressed data memory: 8-bit write port, 32-bit little-endian word read on A, 8-bit read on B.
- Requester 0 is the processor load/store path. Requester 1 is the image loader/filter engine.
- Grants one transaction at a time, serialises 32-bit stores into four byte writes, times reads against the memory's negedge-registered outputs, and rejects out-of-range addresses.

Parameters:
- AW, 32, address width.
- MEM_TOP, 131072, highest valid byte address.
- RR_EN, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  transaction request.
- we0 / we1  in  1  1 = write, 0 = read.
- sz0 / sz1  in  1  0 = byte, 1 = word (4 bytes, little-endian).
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  32  write data; byte access uses [7:0].
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, fields latched.
- done0 / done1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  one-cycle pulse: address out of range, no memory access.
- rdata0 / rdata1  out  32  read data; byte read zero-extended; valid while done is high.
- mem_we_n  out  1  memory write enable, active low.
- mem_a  out  AW  memory address A (write and word read).
- mem_din  out  8  memory write byte.
- mem_b  out  AW  memory byte-read address B.
- mem_do  in  32  memory word read data.
- mem_dob  in  8  memory byte read data.

Behaviour:
- Reset (async, immediate): mem_we_n=1. All other outputs 0. State IDLE. last_grant=1, so requester 0 wins the first conflict. Asserting rst_n low mid-write must raise mem_we_n in the same cycle, with no further byte written. An aborted word write may leave a partial word in memory; that is acceptable.
- All outputs are registered.
- States: IDLE, WR, RD, FIN.
- IDLE, at edge k:
  - Sample req0/req1 and pick a winner. Conflict with RR_EN=1: the requester not in last_grant wins. RR_EN=0: requester 0 wins.
  - Latch the winner's we/sz/addr/wdata, pulse its gnt for cycle k..k+1, update last_grant.
  - Range check: addr > MEM_TOP, or sz=1 and addr+3 > MEM_TOP, gives err pulse (same cycle as gnt). No memory access; stay in IDLE.
- Write, byte: drive mem_a=addr, mem_din=wdata[7:0], mem_we_n=0 for one cycle (memory writes at edge k+1). Go to FIN.
- Write, word: WR state with 2-bit counter c=0..3. Drive mem_a=addr+c, mem_din=wdata[8c+7:8c], mem_we_n=0. Byte c is written at edge k+1+c. After c=3 go to FIN.
- Read, byte: drive mem_b=addr; mem_we_n stays 1. RD state for one cycle (memory registers on the intervening negedge). At edge k+1 capture {24'b0, mem_dob} into rdata of the owner. Go to FIN.
- Read, word: drive mem_a=addr with mem_we_n=1. At edge k+1 capture mem_do. Go to FIN.
- FIN: pulse done of the owner for one cycle, with mem_we_n=1. Return to IDLE.
- Latency from acceptance edge k:
  - Byte write: done in cycle k+1..k+2.
  - Word write: done in cycle k+4..k+5.
  - Reads: rdata and done in cycle k+1..k+2.
- New acceptances happen only in IDLE. A non-winning request stays pending, with no loss and no gnt, until IDLE.
- Requester rule: fields held stable while req is high until gnt. req must drop in the gnt cycle unless a new transaction is intended.
- rdata holds its value until the next read for that requester.
- mem_a/mem_b hold their last value when idle. mem_din = 0 when not writing.
- Address arithmetic is AW-bit. Misaligned word access is legal.

Test Plan:
- Reset mid-word-write: start a word write of 0xAABBCCDD at 0x100; pull rst_n low during the c=1 cycle. Required: mem_we_n=1 immediately; mem[0x100]=0xDD; mem[0x102..0x103] unchanged; outputs 0.
- Word write then read: req0 word write 0x11223344 at 0x40, then word read 0x40. Required: mem_we_n low 4 cycles; bytes 0x44,0x33,0x22,0x11 at 0x40..0x43; done0 at k+4; rdata0=0x11223344 with done0 at k+1.
- Byte read via B: mem[0x1F]=0x7E; req1 byte read 0x1F. Required: mem_b=0x1F; rdata1=0x0000007E with done1 one cycle after gnt1.
- Conflict, RR_EN=1: req0 and req1 both held high for 4 byte reads. Required: grants alternate 0,1,0,1 starting with 0; no gnt while busy.
- Range check: word read at 131070 and byte write at 131073. Required: err pulse with gnt; no mem_we_n low, no done. Byte read at 131072 succeeds.
- Fixed priority, RR_EN=0: req0 and req1 both asserted. Required: req1 waits until req0 drops; no starvation of req0.
